riscv_obi_ram_arbiter: RTL and testbench

- Shares one OBI slave port (RAM, fronted by the response-stall FIFO) between two OBI masters: port 0 = instruction fetch, port 1 = data.
- Arbitrates each request, keeps an in-order ID queue of outstanding transactions, and routes every rvalid/rdata back to the owning master.
- Sits between the core's instr/data OBI masters and the single-port testbench RAM plus response-stall path.

---
 rtl/riscv_obi_arb_pkg.sv | 22 ++
 rtl/riscv_obi_id_fifo.sv | 69 ++++++
 rtl/riscv_obi_ram_arbiter.sv | 147 ++++++++++++++
 tb/tb_riscv_obi_ram_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_obi_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : riscv_obi_arb_pkg
// Brief    : Shared types and constants for the instr/data OBI RAM arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_obi_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef logic master_id_t;

    localparam master_id_t INSTR_ID = 1'b0;
    localparam master_id_t DATA_ID  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/riscv_obi_id_fifo.sv
//------------------------------------------------------------------------------
// Module   : riscv_obi_id_fifo
// Brief    : In-order queue of master IDs for outstanding OBI transactions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module riscv_obi_id_fifo
    import riscv_obi_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             data_i,
    input  logic             pop_i,
    output logic             data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [IDX_W:0]   count_o
);

    master_id_t           mem_q [DEPTH];
    master_id_t           mem_d [DEPTH];
    logic [IDX_W:0]       wptr_q, wptr_d;
    logic [IDX_W:0]       rptr_q, rptr_d;
    logic                 w_push;
    logic                 w_pop;

    // Index bits equal: same slot; differing wrap bit distinguishes full from empty.
    assign full_o  = (wptr_q[IDX_W] != rptr_q[IDX_W]) &&
                     (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = wptr_q - rptr_q;
    assign data_o  = mem_q[rptr_q[IDX_W-1:0]];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (w_push) begin
            mem_d[wptr_q[IDX_W-1:0]] = data_i;
            wptr_d = wptr_q + {{IDX_W{1'b0}}, 1'b1};
        end
        if (w_pop) begin
            rptr_d = rptr_q + {{IDX_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '{default: INSTR_ID};
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/riscv_obi_ram_arbiter.sv
//------------------------------------------------------------------------------
// Module   : riscv_obi_ram_arbiter
// Brief    : Two-master (instr/data) to one-slave OBI arbiter with ID routing.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module riscv_obi_ram_arbiter
    import riscv_obi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    arb_mode_i,
    input  logic [1:0]              m_req_i,
    output logic [1:0]              m_gnt_o,
    input  logic [2*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [1:0]              m_we_i,
    input  logic [7:0]              m_be_i,
    input  logic [63:0]             m_wdata_i,
    output logic [1:0]              m_rvalid_o,
    output logic [63:0]             m_rdata_o,
    output logic                    s_req_o,
    input  logic                    s_gnt_i,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [3:0]              s_be_o,
    output logic [31:0]             s_wdata_o,
    input  logic                    s_rvalid_i,
    input  logic [31:0]             s_rdata_i,
    output logic [CNT_W-1:0]        outstanding_o,
    output logic                    err_o
);

    logic       lock_q, lock_d;
    master_id_t sel_q, sel_d;
    master_id_t rr_last_q, rr_last_d;
    logic       err_q, err_d;

    master_id_t w_sel;
    master_id_t w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_sreq;
    logic       w_hs;
    logic       w_pop;
    arb_mode_e  w_mode;

    assign w_mode = arb_mode_e'(arb_mode_i);

    // A stalled request pins the selection so the slave sees stable attributes.
    always_comb begin
        w_sel = INSTR_ID;
        if (lock_q) begin
            w_sel = sel_q;
        end else if (m_req_i[DATA_ID] && m_req_i[INSTR_ID]) begin
            w_sel = (w_mode == ARB_RR) ? master_id_t'(~rr_last_q) : DATA_ID;
        end else if (m_req_i[DATA_ID]) begin
            w_sel = DATA_ID;
        end
    end

    assign w_sreq = m_req_i[w_sel] && !w_full;
    assign w_hs   = w_sreq && s_gnt_i;
    assign w_pop  = s_rvalid_i && !w_empty;

    always_comb begin
        s_req_o   = w_sreq;
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        m_gnt_o   = '0;
        if (w_sreq) begin
            s_addr_o  = w_sel ? m_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_addr_i[ADDR_WIDTH-1:0];
            s_we_o    = m_we_i[w_sel];
            s_be_o    = w_sel ? m_be_i[7:4] : m_be_i[3:0];
            s_wdata_o = w_sel ? m_wdata_i[63:32] : m_wdata_i[31:0];
        end
        if (w_hs) begin
            m_gnt_o[w_sel] = 1'b1;
        end
    end

    always_comb begin
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        if (w_pop) begin
            m_rvalid_o[w_head] = 1'b1;
            if (w_head == DATA_ID) begin
                m_rdata_o[63:32] = s_rdata_i;
            end else begin
                m_rdata_o[31:0] = s_rdata_i;
            end
        end
    end

    always_comb begin
        lock_d    = lock_q;
        sel_d     = sel_q;
        rr_last_d = rr_last_q;
        err_d     = err_q | (s_rvalid_i && w_empty);
        if (w_sreq) begin
            lock_d = !s_gnt_i;
            sel_d  = w_sel;
        end
        if (w_hs && (w_mode == ARB_RR)) begin
            rr_last_d = w_sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            sel_q     <= INSTR_ID;
            rr_last_q <= INSTR_ID;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            sel_q     <= sel_d;
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;

    riscv_obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_hs),
        .data_i  (w_sel),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (outstanding_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_riscv_obi_ram_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_riscv_obi_ram_arbiter
// Brief    : Directed vector bench for the instr/data OBI RAM arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_riscv_obi_ram_arbiter;

    localparam logic [31:0] C_A0 = 32'h0000_0200;
    localparam logic [31:0] C_A1 = 32'h0000_0100;
    localparam int          C_NV = 31;

    typedef struct {
        logic        mode;
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic [1:0]  e_gnt;
        logic        e_sreq;
        logic [31:0] e_addr;
        logic [1:0]  e_rv;
        logic [63:0] e_rdata;
        logic [3:0]  e_cnt;
        logic        e_err;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        arb_mode_i;
    logic [1:0]  m_req_i;
    logic [1:0]  m_gnt_o;
    logic [63:0] m_addr_i;
    logic [1:0]  m_we_i;
    logic [7:0]  m_be_i;
    logic [63:0] m_wdata_i;
    logic [1:0]  m_rvalid_o;
    logic [63:0] m_rdata_o;
    logic        s_req_o;
    logic        s_gnt_i;
    logic [31:0] s_addr_o;
    logic        s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_wdata_o;
    logic        s_rvalid_i;
    logic [31:0] s_rdata_i;
    logic [3:0]  outstanding_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs [C_NV];

    always #5 clk_i = ~clk_i;

    riscv_obi_ram_arbiter #(
        .ADDR_WIDTH      (32),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .arb_mode_i    (arb_mode_i),
        .m_req_i       (m_req_i),
        .m_gnt_o       (m_gnt_o),
        .m_addr_i      (m_addr_i),
        .m_we_i        (m_we_i),
        .m_be_i        (m_be_i),
        .m_wdata_i     (m_wdata_i),
        .m_rvalid_o    (m_rvalid_o),
        .m_rdata_o     (m_rdata_o),
        .s_req_o       (s_req_o),
        .s_gnt_i       (s_gnt_i),
        .s_addr_o      (s_addr_o),
        .s_we_o        (s_we_o),
        .s_be_o        (s_be_o),
        .s_wdata_o     (s_wdata_o),
        .s_rvalid_i    (s_rvalid_i),
        .s_rdata_i     (s_rdata_i),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic mode, input logic [1:0] req, input logic gnt,
                                input logic rv, input logic [31:0] rdata,
                                input logic [1:0] e_gnt, input logic e_sreq,
                                input logic [31:0] e_addr, input logic [1:0] e_rv,
                                input logic [63:0] e_rdata, input logic [3:0] e_cnt,
                                input logic e_err);
        vec_t v;
        v.mode = mode; v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_gnt = e_gnt; v.e_sreq = e_sreq; v.e_addr = e_addr; v.e_rv = e_rv;
        v.e_rdata = e_rdata; v.e_cnt = e_cnt; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive(input logic mode, input logic [1:0] req, input logic gnt,
                         input logic rv, input logic [31:0] rdata);
        @(negedge clk_i);
        arb_mode_i = mode;
        m_req_i    = req;
        s_gnt_i    = gnt;
        s_rvalid_i = rv;
        s_rdata_i  = rdata;
        #2;
    endtask

    initial begin
        logic [31:0] d;
        // Single master read
        vecs[0]  = mk(0, 2'b10, 1, 0, 0, 2'b10, 1, C_A1, 2'b00, 64'h0, 0, 0);
        vecs[1]  = mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0,    2'b00, 64'h0, 1, 0);
        vecs[2]  = mk(0, 2'b00, 0, 1, 32'hDEAD_BEEF, 2'b00, 0, 0, 2'b10,
                      {32'hDEAD_BEEF, 32'h0}, 1, 0);
        vecs[3]  = mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0,    2'b00, 64'h0, 0, 0);
        // Fixed priority contention then drain
        for (int i = 0; i < 4; i++) begin
            d = 32'hA0 + 32'(i);
            vecs[4+i] = mk(0, 2'b11, 1, 0, 0, 2'b10, 1, C_A1, 2'b00, 64'h0, 4'(i), 0);
            vecs[8+i] = mk(0, 2'b00, 0, 1, d, 2'b00, 0, 0, 2'b10, {d, 32'h0}, 4'(4-i), 0);
        end
        // Round-robin contention then drain in order
        for (int i = 0; i < 4; i++) begin
            d = 32'h11 * 32'(i + 1);
            if (i % 2 == 0) begin
                vecs[12+i] = mk(1, 2'b11, 1, 0, 0, 2'b10, 1, C_A1, 2'b00, 64'h0, 4'(i), 0);
                vecs[16+i] = mk(1, 2'b00, 0, 1, d, 2'b00, 0, 0, 2'b10, {d, 32'h0}, 4'(4-i), 0);
            end else begin
                vecs[12+i] = mk(1, 2'b11, 1, 0, 0, 2'b01, 1, C_A0, 2'b00, 64'h0, 4'(i), 0);
                vecs[16+i] = mk(1, 2'b00, 0, 1, d, 2'b00, 0, 0, 2'b01, {32'h0, d}, 4'(4-i), 0);
            end
        end
        // One port-1 grant in RR so port 0 wins the next tie, then lock
        vecs[20] = mk(1, 2'b10, 1, 0, 0, 2'b10, 1, C_A1, 2'b00, 64'h0, 0, 0);
        vecs[21] = mk(1, 2'b00, 0, 1, 32'h55, 2'b00, 0, 0, 2'b10, {32'h55, 32'h0}, 1, 0);
        vecs[22] = mk(1, 2'b11, 0, 0, 0, 2'b00, 1, C_A0, 2'b00, 64'h0, 0, 0);
        vecs[23] = mk(0, 2'b11, 0, 0, 0, 2'b00, 1, C_A0, 2'b00, 64'h0, 0, 0);
        vecs[24] = mk(0, 2'b11, 0, 0, 0, 2'b00, 1, C_A0, 2'b00, 64'h0, 0, 0);
        vecs[25] = mk(0, 2'b11, 1, 0, 0, 2'b01, 1, C_A0, 2'b00, 64'h0, 0, 0);
        vecs[26] = mk(0, 2'b00, 0, 1, 32'h66, 2'b00, 0, 0, 2'b01, {32'h0, 32'h66}, 1, 0);
        // Spurious response sets sticky error
        vecs[27] = mk(0, 2'b00, 0, 1, 32'h77, 2'b00, 0, 0, 2'b00, 64'h0, 0, 0);
        vecs[28] = mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 64'h0, 0, 1);
        vecs[29] = mk(0, 2'b01, 1, 0, 0, 2'b01, 1, C_A0, 2'b00, 64'h0, 0, 1);
        vecs[30] = mk(0, 2'b00, 0, 1, 32'h88, 2'b00, 0, 0, 2'b01, {32'h0, 32'h88}, 1, 1);

        rst_ni     = 1'b0;
        arb_mode_i = 1'b0;
        m_req_i    = 2'b00;
        m_addr_i   = {C_A1, C_A0};
        m_we_i     = 2'b00;
        m_be_i     = 8'h3F;
        m_wdata_i  = {32'h1111_1111, 32'h2222_2222};
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b0;
        s_rdata_i  = 32'h0;
        #12;
        chk("reset outstanding", 64'(outstanding_o), 64'h0);
        chk("reset err", 64'(err_o), 64'h0);
        chk("reset s_req", 64'(s_req_o), 64'h0);
        chk("reset m_rvalid", 64'(m_rvalid_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < C_NV; i++) begin
            drive(vecs[i].mode, vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            chk($sformatf("v%0d m_gnt", i),    64'(m_gnt_o),       64'(vecs[i].e_gnt));
            chk($sformatf("v%0d s_req", i),    64'(s_req_o),       64'(vecs[i].e_sreq));
            chk($sformatf("v%0d s_addr", i),   64'(s_addr_o),      64'(vecs[i].e_addr));
            chk($sformatf("v%0d m_rvalid", i), 64'(m_rvalid_o),    64'(vecs[i].e_rv));
            chk($sformatf("v%0d m_rdata", i),  m_rdata_o,          vecs[i].e_rdata);
            chk($sformatf("v%0d count", i),    64'(outstanding_o), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d err", i),      64'(err_o),         64'(vecs[i].e_err));
        end

        // Reset pulse clears the sticky error
        drive(0, 2'b00, 0, 0, 0);
        rst_ni = 1'b0;
        #1;
        chk("rst pulse err", 64'(err_o), 64'h0);
        chk("rst pulse count", 64'(outstanding_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fill the ID queue without responses
        for (int i = 0; i < 8; i++) begin
            drive(0, 2'b01, 1, 0, 0);
            chk($sformatf("fill%0d m_gnt", i), 64'(m_gnt_o), 64'h1);
            chk($sformatf("fill%0d count", i), 64'(outstanding_o), 64'(i));
        end
        drive(0, 2'b01, 1, 0, 0);
        chk("full s_req", 64'(s_req_o), 64'h0);
        chk("full m_gnt", 64'(m_gnt_o), 64'h0);
        chk("full s_addr", 64'(s_addr_o), 64'h0);
        chk("full count", 64'(outstanding_o), 64'h8);
        drive(0, 2'b01, 1, 1, 32'h99);
        chk("full pop s_req", 64'(s_req_o), 64'h0);
        chk("full pop m_rvalid", 64'(m_rvalid_o), 64'h1);
        chk("full pop m_rdata", m_rdata_o, 64'h99);
        chk("full pop count", 64'(outstanding_o), 64'h8);
        drive(0, 2'b01, 0, 0, 0);
        chk("after pop count", 64'(outstanding_o), 64'h7);
        chk("after pop s_req", 64'(s_req_o), 64'h1);
        chk("after pop s_addr", 64'(s_addr_o), 64'(C_A0));
        // Stalled port-0 request stays selected though fixed mode favours port 1
        drive(0, 2'b11, 0, 0, 0);
        chk("locked s_addr", 64'(s_addr_o), 64'(C_A0));

        // Reset mid-operation drops IDs and the lock
        @(negedge clk_i);
        rst_ni  = 1'b0;
        m_req_i = 2'b00;
        #1;
        chk("mid rst count", 64'(outstanding_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(0, 2'b11, 0, 1, 32'hBAD);
        chk("post rst s_addr", 64'(s_addr_o), 64'(C_A1));
        chk("late rvalid routed", 64'(m_rvalid_o), 64'h0);
        drive(0, 2'b00, 0, 0, 0);
        chk("late rvalid err", 64'(err_o), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
